// File: rtl/rsa_exp_ctrl.sv
// Right-to-left square-and-multiply scheduler for modular exponentiation.
// Drives one shared Montgomery multiplier through a start/end handshake.
module rsa_exp_ctrl #(
    parameter int unsigned WIDTH    = 256,
    parameter int unsigned EXP_BITS = 256
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [WIDTH-1:0]    i_n,
    input  logic [EXP_BITS-1:0] i_d,
    input  logic [WIDTH-1:0]    i_t,
    output logic [WIDTH-1:0]    o_result,
    output logic                o_finished,
    output logic                o_ma_start,
    output logic [WIDTH-1:0]    o_ma_a,
    output logic [WIDTH-1:0]    o_ma_b,
    output logic [WIDTH-1:0]    o_ma_n,
    input  logic [WIDTH-1:0]    i_ma_o,
    input  logic                i_ma_end
);

    localparam int unsigned CW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(EXP_BITS - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CHECK    = 3'd1;
    localparam logic [2:0] MUL_REQ  = 3'd2;
    localparam logic [2:0] MUL_WAIT = 3'd3;
    localparam logic [2:0] SQR_REQ  = 3'd4;
    localparam logic [2:0] SQR_WAIT = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    logic [2:0]          state, state_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic [WIDTH-1:0]    n_r, n_d;
    logic [EXP_BITS-1:0] d_r, d_d;
    logic [WIDTH-1:0]    t_r, t_d;
    logic [WIDTH-1:0]    m_r, m_d;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        n_d     = n_r;
        d_d     = d_r;
        t_d     = t_r;
        m_d     = m_r;
        case (state)
            IDLE: begin
                if (i_start) begin
                    n_d     = i_n;
                    d_d     = i_d;
                    t_d     = i_t;
                    m_d     = WIDTH'(1);
                    cnt_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (d_r[cnt]) begin
                    state_d = MUL_REQ;
                end else if (cnt == LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = SQR_REQ;
                end
            end
            MUL_REQ: state_d = MUL_WAIT;
            MUL_WAIT: begin
                if (i_ma_end) begin
                    m_d = i_ma_o;
                    // The square after the final bit would never be used.
                    state_d = (cnt == LAST) ? DONE : SQR_REQ;
                end
            end
            SQR_REQ: state_d = SQR_WAIT;
            SQR_WAIT: begin
                if (i_ma_end) begin
                    t_d     = i_ma_o;
                    cnt_d   = cnt + CW'(1);
                    state_d = CHECK;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            n_r   <= '0;
            d_r   <= '0;
            t_r   <= '0;
            m_r   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            n_r   <= n_d;
            d_r   <= d_d;
            t_r   <= t_d;
            m_r   <= m_d;
        end
    end

    // Operands are decoded from state so they stay stable across REQ and WAIT.
    always_comb begin
        o_ma_a = '0;
        o_ma_b = '0;
        case (state)
            MUL_REQ, MUL_WAIT: begin
                o_ma_a = m_r;
                o_ma_b = t_r;
            end
            SQR_REQ, SQR_WAIT: begin
                o_ma_a = t_r;
                o_ma_b = t_r;
            end
            default: ;
        endcase
    end

    assign o_ma_start = (state == MUL_REQ) || (state == SQR_REQ);
    assign o_finished = (state == DONE);
    assign o_ma_n     = n_r;
    assign o_result   = m_r;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Directed bench for rsa_exp_ctrl with a behavioural Montgomery multiplier (latency 3).
module tb_rsa_exp_ctrl;

    localparam int unsigned WIDTH    = 256;
    localparam int unsigned EXP_BITS = 256;
    localparam int          LAT      = 3;
    localparam logic [WIDTH-1:0] NMOD = 256'd1731;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [WIDTH-1:0]    n_in;
    logic [EXP_BITS-1:0] d_in;
    logic [WIDTH-1:0]    t_in;
    logic [WIDTH-1:0]    result;
    logic                finished;
    logic                ma_start;
    logic [WIDTH-1:0]    ma_a;
    logic [WIDTH-1:0]    ma_b;
    logic [WIDTH-1:0]    ma_n;
    logic [WIDTH-1:0]    ma_o;
    logic                ma_end;

    rsa_exp_ctrl #(
        .WIDTH    (WIDTH),
        .EXP_BITS (EXP_BITS)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_n        (n_in),
        .i_d        (d_in),
        .i_t        (t_in),
        .o_result   (result),
        .o_finished (finished),
        .o_ma_start (ma_start),
        .o_ma_a     (ma_a),
        .o_ma_b     (ma_b),
        .o_ma_n     (ma_n),
        .i_ma_o     (ma_o),
        .i_ma_end   (ma_end)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // a*b*2^-WIDTH mod m, bit-serial.
    function automatic logic [WIDTH-1:0] mont(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] m);
        logic [WIDTH+1:0] s;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) s = s + {2'b00, b};
            if (s[0]) s = s + {2'b00, m};
            s = s >> 1;
        end
        if (s >= {2'b00, m}) s = s - {2'b00, m};
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] to_mont(input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH+1:0] r;
        r = {2'b00, y};
        for (int i = 0; i < WIDTH; i++) begin
            r = r << 1;
            if (r >= {2'b00, m}) r = r - {2'b00, m};
        end
        return r[WIDTH-1:0];
    endfunction

    // Behavioural multiplier plus handshake bookkeeping.
    int               rem = 0;
    logic             model_end = 1'b0;
    logic [WIDTH-1:0] model_o = '0;
    logic [WIDTH-1:0] model_res = '0;
    int               pulses = 0;
    int               muls = 0;
    int               overlaps = 0;
    logic             last_sqr = 1'b0;
    logic             spur = 1'b0;
    logic [WIDTH-1:0] junk = 256'd1234;

    always @(posedge clk) begin
        model_end <= 1'b0;
        if (rem > 0) begin
            rem <= rem - 1;
            if (rem == 1) begin
                model_end <= 1'b1;
                model_o   <= model_res;
            end
        end
        if (ma_start) begin
            if (rem > 0 || model_end) overlaps <= overlaps + 1;
            rem       <= LAT - 1;
            model_res <= mont(ma_a, ma_b, ma_n);
            pulses    <= pulses + 1;
            if (ma_a != ma_b) begin
                muls     <= muls + 1;
                last_sqr <= 1'b0;
            end else begin
                last_sqr <= 1'b1;
            end
        end
    end

    assign ma_end = model_end | spur;
    assign ma_o   = spur ? junk : model_o;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    int c0;
    int p0;
    int m0;

    task automatic start_job(input logic [WIDTH-1:0] y, input logic [EXP_BITS-1:0] d);
        @(negedge clk);
        n_in  = NMOD;
        d_in  = d;
        t_in  = to_mont(y, NMOD);
        start = 1'b1;
        c0    = cyc;
        p0    = pulses;
        m0    = muls;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, output logic [WIDTH-1:0] res, output int lat);
        bit found;
        found = 1'b0;
        res   = '0;
        lat   = -1;
        for (int k = 0; k < 5000 && !found; k++) begin
            @(negedge clk);
            if (finished) begin
                found = 1'b1;
                res   = result;
                lat   = cyc - c0;
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got no o_finished expected within 5000 cycles", name);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0]    y;
        logic [EXP_BITS-1:0] d;
        logic [WIDTH-1:0]    exp_res;
        int                  exp_pulses;
        int                  exp_muls;
        int                  exp_lat;
        bit                  chk_last_mul;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [WIDTH-1:0]    res;
        int                  lat;
        longint              r;
        logic [EXP_BITS-1:0] one;
        int                  p;

        // Reference for 97^(2^255) mod 1731 by plain repeated squaring.
        r = 97;
        for (int i = 0; i < 255; i++) r = (r * r) % 1731;
        one = 1;

        tbl[0] = '{256'd97, 256'd3, 256'd436, 257, 2, 1285, 1'b0};
        tbl[1] = '{256'd97, 256'd0, 256'd1,   255, 0, 1277, 1'b0};
        tbl[2] = '{256'd97, 256'd1, 256'd97,  256, 1, 1281, 1'b0};
        tbl[3] = '{256'd97, one << 255, WIDTH'(r), 256, 1, 1281, 1'b1};
        tbl[4] = '{256'd5,  256'd5, 256'd1394, 257, 2, 1285, 1'b0};

        // Reset held with start asserted.
        rst_n = 1'b0;
        start = 1'b1;
        n_in  = NMOD;
        d_in  = 256'd3;
        t_in  = 256'd5;
        p = pulses;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, '0);
        chk("rst_finished", WIDTH'(finished), '0);
        chk("rst_ma_start", WIDTH'(ma_start), '0);
        chk("rst_ma_a", ma_a, '0);
        chk("rst_ma_b", ma_b, '0);
        chk("rst_ma_n", ma_n, '0);
        chk("rst_pulses", WIDTH'(pulses - p), '0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            start_job(tbl[i].y, tbl[i].d);
            wait_done($sformatf("vec%0d", i), res, lat);
            chk($sformatf("vec%0d_result", i), res, tbl[i].exp_res);
            chk($sformatf("vec%0d_latency", i), WIDTH'(lat), WIDTH'(tbl[i].exp_lat));
            chk($sformatf("vec%0d_pulses", i), WIDTH'(pulses - p0), WIDTH'(tbl[i].exp_pulses));
            chk($sformatf("vec%0d_muls", i), WIDTH'(muls - m0), WIDTH'(tbl[i].exp_muls));
            if (tbl[i].chk_last_mul) chk($sformatf("vec%0d_last_is_mul", i),
                                         WIDTH'(last_sqr), '0);
        end

        // Result holds after completion.
        repeat (3) @(negedge clk);
        chk("hold_result", result, tbl[4].exp_res);

        // Stray start and spurious end while busy, then a back-to-back job.
        start_job(256'd97, 256'd3);
        spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        start = 1'b1;
        d_in  = 256'd0;
        t_in  = 256'd77;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("interf", res, lat);
        chk("interf_result", res, 256'd436);
        chk("interf_latency", WIDTH'(lat), 256'd1285);
        start_job(256'd5, 256'd5);
        wait_done("b2b", res, lat);
        chk("b2b_result", res, 256'd1394);
        chk("b2b_latency", WIDTH'(lat), 256'd1285);

        // Reset while the first multiply is in flight.
        start_job(256'd97, 256'd3);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ma_a", ma_a, '0);
        chk("midrst_ma_n", ma_n, '0);
        chk("midrst_result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        p = pulses;
        repeat (8) @(negedge clk);
        chk("midrst_no_pulses", WIDTH'(pulses - p), '0);
        chk("midrst_idle_result", result, '0);
        start_job(256'd97, 256'd3);
        wait_done("restart", res, lat);
        chk("restart_result", res, 256'd436);
        chk("restart_latency", WIDTH'(lat), 256'd1285);

        chk("no_overlap", WIDTH'(overlaps), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsa_exp_ctrl.md
# rsa_exp_ctrl

Modular-exponentiation scheduler for the RSA-256 core. Computes m = y^d mod n by right-to-left square-and-multiply, sequencing one shared external Montgomery multiplier (MontAlg) through a start/end handshake and holding the running product and square in internal registers. Sits between the top-level RSA wrapper, which supplies the pre-transformed base t = y·2^WIDTH mod n, and the single multiplier instance.

## Interface
- WIDTH, 256: operand / modulus width.
- EXP_BITS, 256: exponent bits scanned, LSB first.

- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_n  in  WIDTH  modulus, latched on accepted start.
- i_d  in  EXP_BITS  exponent, latched on accepted start.
- i_t  in  WIDTH  base in Montgomery domain, latched on accepted start.
- o_result  out  WIDTH  y^d mod n; valid while o_finished=1.
- o_finished  out  1  one-cycle completion pulse.
- o_ma_start  out  1  one-cycle multiplier start pulse.
- o_ma_a, o_ma_b, o_ma_n  out  WIDTH  multiplier operands.
- i_ma_o  in  WIDTH  multiplier result.
- i_ma_end  in  1  multiplier done; result valid this cycle.

## Operation
- Registers: n_r, d_r, t_r, m_r (WIDTH), cnt (clog2(EXP_BITS) bits), state.
- States: IDLE, CHECK, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, DONE.
- IDLE: on i_start=1 latch n_r, d_r, t_r; m_r<=1; cnt<=0; ->CHECK. Otherwise stay.
- CHECK: d_r[cnt]=1 ->MUL_REQ; else if cnt==EXP_BITS-1 ->DONE; else ->SQR_REQ.
- MUL_REQ: o_ma_start=1, a=m_r, b=t_r ->MUL_WAIT.
- MUL_WAIT: on i_ma_end, m_r<=i_ma_o; then cnt==EXP_BITS-1 ->DONE else ->SQR_REQ.
- SQR_REQ: o_ma_start=1, a=t_r, b=t_r ->SQR_WAIT.
- SQR_WAIT: on i_ma_end, t_r<=i_ma_o; cnt<=cnt+1; ->CHECK.
- Squaring on the last exponent bit is skipped (result unused).
- DONE: o_finished=1, o_result=m_r; ->IDLE.
- o_ma_n = n_r always. o_ma_a/o_ma_b held stable from the REQ cycle through the cycle i_ma_end is seen.
- m_r stays in the plain domain (1 · y·R · R^-1 = y), so no post-transform.
- d=0: no multiplies, EXP_BITS-1 squarings, result 1.
- i_start while not IDLE: ignored. i_ma_end outside a WAIT state: ignored.
- No overflow handling; i_t < i_n and n odd are caller obligations.

## Timing
- Reset (i_rst_n=0 at an edge): state=IDLE, cnt=0, all data registers 0, o_finished=0, o_ma_start=0, o_result=0, o_ma_a/b/n=0. Reset mid-exponentiation aborts immediately; no further o_ma_start pulses; an in-flight i_ma_end is ignored.
- o_ma_start high exactly one cycle per multiplier op, never while a previous op is outstanding.
- Multiplier latency L ≥ 1: i_ma_end in cycle k+L when o_ma_start in cycle k; op occupies L+1 cycles.
- With i_start accepted in cycle 0 and P = number of multiplier ops: o_finished asserts in cycle 1 + EXP_BITS + P·(L+1).
- P = popcount(d) + (EXP_BITS-1).
- New i_start accepted in the cycle after DONE (back-to-back permitted).
- o_result holds m_r after DONE until next start or reset.

## Test plan
- Reset: hold i_rst_n=0 two cycles with i_start=1 -> all outputs 0, no o_ma_start.
- Bench behavioural MontAlg (a·b·2^-256 mod n, L=3); y=97, d=3, n=1731, t computed by bench -> o_result=436, exactly 257 o_ma_start pulses, o_finished at cycle 1+256+257·4=1285.
- d=0, same n/t -> o_result=1, 255 pulses, no MUL_REQ operands with a=m_r.
- d=1 -> o_result=97; d=2^255 -> result equals bench reference pow(97,2^255,1731); squarings-only until final multiply, no squaring after bit 255.
- Pulse i_start during run and spurious i_ma_end in CHECK -> ignored, result unchanged; back-to-back second job with different y starts cycle after o_finished and is correct.
- Assert i_rst_n=0 mid MUL_WAIT, then restart -> no stale i_ma_end captured, second run correct.
